// File: rtl/memory_arbiter.sv
// memory_arbiter: two-requester (instruction / data) arbiter onto a single
// generic-bus downstream port. Round-robin on simultaneous requests, grant
// held for the whole transfer, one IDLE bubble between grants.
module memory_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  // instruction requester
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_ren,
  input  logic              i_wen,
  input  logic [31:0]       i_wdata,
  input  logic [3:0]        i_byte_en,
  output logic [31:0]       i_rdata,
  output logic              i_busy,
  // data requester
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_byte_en,
  output logic [31:0]       d_rdata,
  output logic              d_busy,
  // downstream bus
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_ren,
  output logic              o_wen,
  output logic [31:0]       o_wdata,
  output logic [3:0]        o_byte_en,
  input  logic [31:0]       o_rdata,
  input  logic              o_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  state_e state_q, state_d;
  grant_e last_grant_q, last_grant_d;

  logic i_req;
  logic d_req;

  assign i_req = i_ren | i_wen;
  assign d_req = d_ren | d_wen;

  // Next-state: pick a port from IDLE, hold the grant until completion or abort.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        // On a tie the port that did not win last time goes first.
        if (d_req && (!i_req || (last_grant_q == GRANT_I))) begin
          state_d      = SERVE_D;
          last_grant_d = GRANT_D;
        end else if (i_req) begin
          state_d      = SERVE_I;
          last_grant_d = GRANT_I;
        end
      end
      SERVE_I: begin
        // Requester dropping its request aborts; otherwise wait for not-busy.
        if (!i_req || !o_busy) begin
          state_d = IDLE;
        end
      end
      SERVE_D: begin
        if (!d_req || !o_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and round-robin registers; reset leaves data with first turn.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Output mux: the granted port is passed straight through, the other is stalled.
  always_comb begin
    o_addr    = '0;
    o_ren     = 1'b0;
    o_wen     = 1'b0;
    o_wdata   = '0;
    o_byte_en = '0;
    i_busy    = 1'b1;
    d_busy    = 1'b1;
    unique case (state_q)
      SERVE_I: begin
        o_addr    = i_addr;
        o_ren     = i_ren;
        o_wen     = i_wen;
        o_wdata   = i_wdata;
        o_byte_en = i_byte_en;
        i_busy    = o_busy;
      end
      SERVE_D: begin
        o_addr    = d_addr;
        o_ren     = d_ren;
        o_wen     = d_wen;
        o_wdata   = d_wdata;
        o_byte_en = d_byte_en;
        d_busy    = o_busy;
      end
      default: begin
      end
    endcase
  end

  // Read data is broadcast; only the non-busy port treats it as valid.
  assign i_rdata = o_rdata;
  assign d_rdata = o_rdata;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: per-cycle vector table plus a
// hand-written reset-during-transfer sequence.
module tb_memory_arbiter;

  localparam int ADDR_W = 32;
  localparam int GN = 0;
  localparam int GI = 1;
  localparam int GD = 2;

  localparam logic [31:0] I_ADDR  = 32'h0000_0200;
  localparam logic [31:0] D_ADDR  = 32'h0000_0100;
  localparam logic [31:0] I_WDATA = 32'hAAAA_5555;
  localparam logic [31:0] D_WDATA = 32'h1234_5678;
  localparam logic [3:0]  I_BE    = 4'hF;
  localparam logic [3:0]  D_BE    = 4'b0011;

  logic              CLK;
  logic              nRST;
  logic [ADDR_W-1:0] i_addr, d_addr, o_addr;
  logic              i_ren, i_wen, d_ren, d_wen, o_ren, o_wen;
  logic [31:0]       i_wdata, d_wdata, o_wdata;
  logic [3:0]        i_byte_en, d_byte_en, o_byte_en;
  logic [31:0]       i_rdata, d_rdata, o_rdata;
  logic              i_busy, d_busy, o_busy;

  memory_arbiter #(.ADDR_W(ADDR_W)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .i_addr    (i_addr),
    .i_ren     (i_ren),
    .i_wen     (i_wen),
    .i_wdata   (i_wdata),
    .i_byte_en (i_byte_en),
    .i_rdata   (i_rdata),
    .i_busy    (i_busy),
    .d_addr    (d_addr),
    .d_ren     (d_ren),
    .d_wen     (d_wen),
    .d_wdata   (d_wdata),
    .d_byte_en (d_byte_en),
    .d_rdata   (d_rdata),
    .d_busy    (d_busy),
    .o_addr    (o_addr),
    .o_ren     (o_ren),
    .o_wen     (o_wen),
    .o_wdata   (o_wdata),
    .o_byte_en (o_byte_en),
    .o_rdata   (o_rdata),
    .o_busy    (o_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic rst;
    logic ir, iw, dr, dw, ob;
    int   g;
    logic oren, owen, ib, db;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  int   starve_idx;
  int   d_done, i_done;

  function automatic vec_t v(input logic rst, input logic ir, input logic iw,
                             input logic dr, input logic dw, input logic ob,
                             input int g, input logic oren, input logic owen,
                             input logic ib, input logic db);
    vec_t r;
    r.rst = rst; r.ir = ir; r.iw = iw; r.dr = dr; r.dw = dw; r.ob = ob;
    r.g = g; r.oren = oren; r.owen = owen; r.ib = ib; r.db = db;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " o_ren"},     32'(o_ren),     32'd0);
    check({tag, " o_wen"},     32'(o_wen),     32'd0);
    check({tag, " o_addr"},    o_addr,         32'd0);
    check({tag, " o_wdata"},   o_wdata,        32'd0);
    check({tag, " o_byte_en"}, 32'(o_byte_en), 32'd0);
    check({tag, " i_busy"},    32'(i_busy),    32'd1);
    check({tag, " d_busy"},    32'(d_busy),    32'd1);
  endtask

  initial begin
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    string       tag;

    i_addr = I_ADDR; d_addr = D_ADDR;
    i_wdata = I_WDATA; d_wdata = D_WDATA;
    i_byte_en = I_BE; d_byte_en = D_BE;
    o_rdata = 32'hDEAD_BEEF;

    // Reset with requests already asserted: everything must stay parked.
    nRST = 1'b0;
    i_ren = 1'b1; i_wen = 1'b0; d_ren = 1'b0; d_wen = 1'b1; o_busy = 1'b0;
    #3;
    check_idle_outputs("reset");
    @(posedge CLK);
    #1;
    check_idle_outputs("reset_held");
    @(negedge CLK);
    i_ren = 1'b0; d_wen = 1'b0;
    nRST = 1'b1;

    // Single read on the data port.
    vecs.push_back(v(0, 0,0,0,0,0, GN, 0,0,1,1));
    vecs.push_back(v(0, 0,0,1,0,0, GN, 0,0,1,1));
    vecs.push_back(v(0, 0,0,1,0,0, GD, 1,0,1,0));
    vecs.push_back(v(0, 0,0,0,0,0, GN, 0,0,1,1));
    // Tie after reset (D first, write passthrough), then second tie grants I.
    vecs.push_back(v(1, 1,0,0,1,1, GN, 0,0,1,1));
    vecs.push_back(v(0, 1,0,0,1,1, GD, 0,1,1,1));
    vecs.push_back(v(0, 1,0,0,1,1, GD, 0,1,1,1));
    vecs.push_back(v(0, 1,0,0,1,0, GD, 0,1,1,0));
    vecs.push_back(v(0, 1,0,0,1,0, GN, 0,0,1,1));
    vecs.push_back(v(0, 1,0,0,1,0, GI, 1,0,0,1));
    vecs.push_back(v(0, 0,0,0,1,0, GN, 0,0,1,1));
    vecs.push_back(v(0, 0,0,0,1,0, GD, 0,1,1,0));
    vecs.push_back(v(0, 0,0,0,0,0, GN, 0,0,1,1));
    // Abort of an I transfer with a pending D request.
    vecs.push_back(v(1, 1,0,0,0,1, GN, 0,0,1,1));
    vecs.push_back(v(0, 1,0,0,0,1, GI, 1,0,1,1));
    vecs.push_back(v(0, 1,0,0,0,1, GI, 1,0,1,1));
    vecs.push_back(v(0, 0,0,1,0,1, GI, 0,0,1,1));
    vecs.push_back(v(0, 0,0,1,0,1, GN, 0,0,1,1));
    vecs.push_back(v(0, 0,0,1,0,0, GD, 1,0,1,0));
    vecs.push_back(v(0, 0,0,0,0,0, GN, 0,0,1,1));
    // ren and wen together are forwarded unchanged.
    vecs.push_back(v(0, 0,0,1,1,0, GN, 0,0,1,1));
    vecs.push_back(v(0, 0,0,1,1,0, GD, 1,1,1,0));
    vecs.push_back(v(0, 0,0,0,0,0, GN, 0,0,1,1));
    // Both ports requesting continuously: strict D,I alternation.
    starve_idx = vecs.size();
    for (int t = 0; t < 10; t++) begin
      vecs.push_back(v((t == 0) ? 1'b1 : 1'b0, 1,0,1,0,0, GN, 0,0,1,1));
      if (t % 2 == 0) vecs.push_back(v(0, 1,0,1,0,0, GD, 1,0,1,0));
      else            vecs.push_back(v(0, 1,0,1,0,0, GI, 1,0,0,1));
    end
    vecs.push_back(v(0, 0,0,0,0,0, GN, 0,0,1,1));

    d_done = 0;
    i_done = 0;
    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge CLK);
      if (vecs[k].rst) begin
        nRST = 1'b0;
        #1;
        nRST = 1'b1;
      end
      i_ren = vecs[k].ir; i_wen = vecs[k].iw;
      d_ren = vecs[k].dr; d_wen = vecs[k].dw;
      o_busy = vecs[k].ob;
      o_rdata = (k < 4) ? 32'hDEAD_BEEF : $urandom;
      #1;
      case (vecs[k].g)
        GI:      begin exp_addr = I_ADDR; exp_wdata = I_WDATA; exp_be = I_BE; end
        GD:      begin exp_addr = D_ADDR; exp_wdata = D_WDATA; exp_be = D_BE; end
        default: begin exp_addr = '0;     exp_wdata = '0;      exp_be = '0;   end
      endcase
      tag = $sformatf("row%0d", k);
      check({tag, " o_ren"},     32'(o_ren),     32'(vecs[k].oren));
      check({tag, " o_wen"},     32'(o_wen),     32'(vecs[k].owen));
      check({tag, " o_addr"},    o_addr,         exp_addr);
      check({tag, " o_wdata"},   o_wdata,        exp_wdata);
      check({tag, " o_byte_en"}, 32'(o_byte_en), 32'(exp_be));
      check({tag, " i_busy"},    32'(i_busy),    32'(vecs[k].ib));
      check({tag, " d_busy"},    32'(d_busy),    32'(vecs[k].db));
      check({tag, " i_rdata"},   i_rdata,        o_rdata);
      check({tag, " d_rdata"},   d_rdata,        o_rdata);
      if (k >= starve_idx) begin
        if ((d_ren | d_wen) && !d_busy) d_done++;
        if ((i_ren | i_wen) && !i_busy) i_done++;
      end
    end
    check("starve d_completions", 32'(d_done), 32'd5);
    check("starve i_completions", 32'(i_done), 32'd5);

    // Reset in the middle of a stalled D write.
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    nRST = 1'b1;
    i_ren = 1'b0; i_wen = 1'b0; d_ren = 1'b0; d_wen = 1'b1; o_busy = 1'b1;
    @(negedge CLK);
    #1;
    check("midrst pre o_wen",  32'(o_wen),  32'd1);
    check("midrst pre d_busy", 32'(d_busy), 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    check_idle_outputs("midrst async");
    @(posedge CLK);
    #1;
    check_idle_outputs("midrst held");
    @(negedge CLK);
    nRST = 1'b1;
    i_ren = 1'b1;
    #1;
    check_idle_outputs("midrst idle");
    @(negedge CLK);
    #1;
    check("midrst regrant o_wen",  32'(o_wen),  32'd1);
    check("midrst regrant o_ren",  32'(o_ren),  32'd0);
    check("midrst regrant o_addr", o_addr,      D_ADDR);
    check("midrst regrant i_busy", 32'(i_busy), 32'd1);
    o_busy = 1'b0;
    #1;
    check("midrst regrant d_busy", 32'(d_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
